// File: rtl/diff_accum_if.sv
// Bundle of the diff_accum control, sample and result signals.
// Handshake: start/sa_valid are sampled only on rising edges; done stays high until ack is seen in DONE.
interface diff_accum_if #(
    parameter int SUM_W = 16
);
    logic             start;
    logic [9:0]       sa;
    logic             sa_valid;
    logic             ack;
    logic [SUM_W-1:0] sum;
    logic [9:0]       peak;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, sa, sa_valid, ack,
        input  sum, peak, ovf, busy, done
    );

    modport slave (
        input  start, sa, sa_valid, ack,
        output sum, peak, ovf, busy, done
    );
endinterface

// File: rtl/diff_accum.sv
// Windowed saturating accumulator of absolute-difference samples with done/ack result handshake.
// Optional peak tracking is enabled by defining DIFF_ACCUM_PEAK_EN.
module diff_accum #(
    parameter int NSAMP = 16,
    parameter int SUM_W = 16
) (
    input  logic        m_clock,
    input  logic        p_reset,
    diff_accum_if.slave bus,
    output logic [1:0]  dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [SUM_W:0]   sum_ext;
    logic             clear_w;

    // Extra top bit catches an add that would pass the saturation ceiling.
    assign sum_ext = {1'b0, sum_q} + {{(SUM_W-9){1'b0}}, bus.sa};
    assign clear_w = bus.start && (state_q != S_DONE);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (!bus.start && bus.sa_valid) begin
                    cnt_d = cnt_q + 8'd1;
                    if (sum_ext[SUM_W]) begin
                        sum_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        sum_d = sum_ext[SUM_W-1:0];
                    end
                    if (cnt_q == 8'(NSAMP-1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_w) begin
            sum_d = '0;
            ovf_d = 1'b0;
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DIFF_ACCUM_PEAK_EN
    logic [9:0] peak_q, peak_d;
    logic       accept_w;

    assign accept_w = (state_q == S_ACCUM) && !bus.start && bus.sa_valid;

    always_comb begin
        peak_d = peak_q;
        if (clear_w) peak_d = '0;
        else if (accept_w && (bus.sa > peak_q)) peak_d = bus.sa;
    end

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) peak_q <= '0;
        else         peak_q <= peak_d;
    end

    assign bus.peak = peak_q;
`else
    assign bus.peak = '0;
`endif

    assign bus.sum     = sum_q;
    assign bus.ovf     = ovf_q;
    assign bus.busy    = (state_q == S_ACCUM);
    assign bus.done    = (state_q == S_DONE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_diff_accum.sv
// Randomized self-checking bench for diff_accum: two instances (NSAMP=4/SUM_W=16 and NSAMP=16/SUM_W=10)
// checked every cycle against a window-queue reference model.
module tb_diff_accum;
    logic m_clock = 1'b0;
    logic p_reset;
    always #5 m_clock = ~m_clock;

    diff_accum_if #(.SUM_W(16)) bif_a();
    diff_accum_if #(.SUM_W(10)) bif_b();
    logic [1:0] dbg_a, dbg_b;

    diff_accum #(.NSAMP(4), .SUM_W(16)) dut_a (
        .m_clock(m_clock), .p_reset(p_reset), .bus(bif_a), .dbg_state_o(dbg_a)
    );
    diff_accum #(.NSAMP(16), .SUM_W(10)) dut_b (
        .m_clock(m_clock), .p_reset(p_reset), .bus(bif_b), .dbg_state_o(dbg_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which instance is driven, its window length and sum width,
    // the phase (0 idle, 1 accumulating, 2 result held) and the samples accepted so far.
    int sel   = 0;
    int nsamp = 4;
    int sumw  = 16;
    int mode  = 0;
    int win_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint raw_sum();
        longint s = 0;
        foreach (win_q[i]) s += win_q[i];
        return s;
    endfunction

    function automatic longint sat_max();
        return (longint'(1) << sumw) - 1;
    endfunction

    function automatic int exp_peak();
        int p = 0;
`ifdef DIFF_ACCUM_PEAK_EN
        foreach (win_q[i]) if (win_q[i] > p) p = win_q[i];
`endif
        return p;
    endfunction

    function automatic logic [31:0] exp_sum();
        longint s = raw_sum();
        return (s > sat_max()) ? 32'(sat_max()) : 32'(s);
    endfunction

    task automatic compare_all(input int which);
        logic [31:0] o_sum, o_peak, o_ovf, o_busy, o_done, o_st;
        if (which == 0) begin
            o_sum = 32'(bif_a.sum); o_peak = 32'(bif_a.peak); o_ovf = 32'(bif_a.ovf);
            o_busy = 32'(bif_a.busy); o_done = 32'(bif_a.done); o_st = 32'(dbg_a);
        end else begin
            o_sum = 32'(bif_b.sum); o_peak = 32'(bif_b.peak); o_ovf = 32'(bif_b.ovf);
            o_busy = 32'(bif_b.busy); o_done = 32'(bif_b.done); o_st = 32'(dbg_b);
        end
        check("sum",   o_sum,  exp_sum());
        check("ovf",   o_ovf,  32'(raw_sum() > sat_max()));
        check("peak",  o_peak, 32'(exp_peak()));
        check("busy",  o_busy, 32'(mode == 1));
        check("done",  o_done, 32'(mode == 2));
        check("state", o_st,   32'(mode));
    endtask

    task automatic drive(input bit st, input bit vl, input logic [9:0] s, input bit ak);
        bif_a.start = 1'b0; bif_a.sa_valid = 1'b0; bif_a.sa = '0; bif_a.ack = 1'b0;
        bif_b.start = 1'b0; bif_b.sa_valid = 1'b0; bif_b.sa = '0; bif_b.ack = 1'b0;
        if (sel == 0) begin
            bif_a.start = st; bif_a.sa_valid = vl; bif_a.sa = s; bif_a.ack = ak;
        end else begin
            bif_b.start = st; bif_b.sa_valid = vl; bif_b.sa = s; bif_b.ack = ak;
        end
    endtask

    // One clock: inputs change at the falling edge, model advances at the rising edge,
    // outputs are compared at the next falling edge.
    task automatic cycle(input bit st, input bit vl, input int s, input bit ak);
        drive(st, vl, 10'(s), ak);
        @(posedge m_clock);
        case (mode)
            0: if (st) begin mode = 1; win_q.delete(); end
            1: begin
                if (st) win_q.delete();
                else if (vl) begin
                    win_q.push_back(s);
                    if (win_q.size() == nsamp) mode = 2;
                end
            end
            default: if (ak) mode = 0;
        endcase
        @(negedge m_clock);
        compare_all(sel);
    endtask

    // Asserted between edges so the clear must be seen without a clock.
    task automatic pulse_reset();
        drive(1'b0, 1'b0, 10'd0, 1'b0);
        #2 p_reset = 1'b1;
        mode = 0;
        win_q.delete();
        #1;
        compare_all(0);
        compare_all(1);
        @(negedge m_clock);
        p_reset = 1'b0;
        #1;
        compare_all(sel);
    endtask

    task automatic rand_cycles(input int n, input int start_den);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else cycle($urandom_range(0, start_den - 1) == 0,
                       $urandom_range(0, 9) < 7,
                       int'($urandom_range(0, 127)),
                       $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        p_reset = 1'b1;
        drive(1'b0, 1'b0, 10'd0, 1'b0);
        @(negedge m_clock);
        compare_all(0);
        compare_all(1);
        p_reset = 1'b0;
        @(negedge m_clock);

        // Scenario: samples 3,5,0,7 -> result one cycle after the 4th
        cycle(1, 0, 0, 0);
        cycle(0, 1, 3, 0); cycle(0, 1, 5, 0); cycle(0, 1, 0, 0);
        cycle(0, 1, 7, 0);
        check("s1_done", 32'(bif_a.done), 32'd1);
        check("s1_sum",  32'(bif_a.sum),  32'd15);
        check("s1_ovf",  32'(bif_a.ovf),  32'd0);
`ifdef DIFF_ACCUM_PEAK_EN
        check("s1_peak", 32'(bif_a.peak), 32'd7);
`else
        check("s1_peak", 32'(bif_a.peak), 32'd0);
`endif
        // start/sa_valid ignored while the result is held
        for (int i = 0; i < 3; i++) cycle(1, 1, 50, 0);
        check("s4_sum",  32'(bif_a.sum),  32'd15);
        check("s4_done", 32'(bif_a.done), 32'd1);
        cycle(0, 0, 0, 1);
        check("s4_done_after_ack", 32'(bif_a.done), 32'd0);
        check("s4_sum_after_ack",  32'(bif_a.sum),  32'd15);
        cycle(0, 1, 33, 1);

        // Restart mid-window; samples coincident with start are dropped
        cycle(1, 1, 60, 0);
        cycle(0, 1, 9, 0); cycle(0, 1, 9, 0);
        cycle(1, 1, 9, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0);
        check("s3_sum", 32'(bif_a.sum), 32'd4);
`ifdef DIFF_ACCUM_PEAK_EN
        check("s3_peak", 32'(bif_a.peak), 32'd1);
`else
        check("s3_peak", 32'(bif_a.peak), 32'd0);
`endif
        cycle(0, 0, 0, 1);

        // Reset mid-window, then a clean window
        cycle(1, 0, 0, 0);
        cycle(0, 1, 2, 0); cycle(0, 1, 2, 0);
        pulse_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 2, 0);
        check("s5_sum", 32'(bif_a.sum), 32'd8);
        cycle(0, 0, 0, 1);

        rand_cycles(400, 10);

        // Second instance: 16 samples, 10-bit saturating sum
        pulse_reset();
        sel = 1; nsamp = 16; sumw = 10;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 100, 0);
        check("s2_sum",  32'(bif_b.sum),  32'd1023);
        check("s2_ovf",  32'(bif_b.ovf),  32'd1);
        check("s2_done", 32'(bif_b.done), 32'd1);
        cycle(0, 0, 0, 1);

        // Landing exactly on the ceiling is not an overflow
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) cycle(0, 1, 64, 0);
        cycle(0, 1, 63, 0);
        check("edge_sum", 32'(bif_b.sum), 32'd1023);
        check("edge_ovf", 32'(bif_b.ovf), 32'd0);
        cycle(0, 0, 0, 1);

        rand_cycles(600, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
